// File: rtl/wide_adder_sequencer_pkg.sv
// Shared types and helpers for the slice-serial wide add/subtract unit.
package wide_adder_sequencer_pkg;

    // Sequencer control states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_e;

    // Counter width for a given slice count; a single-slice unit still needs one bit
    function automatic int unsigned cnt_width(input int unsigned steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

    // Two's-complement overflow from the top-bit signs of the operands and the result
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/wide_adder_sequencer_carry_select_adder.sv
// N-bit carry-select adder: each SIZE-bit block precomputes both carry cases.
module carry_select_adder #(
    parameter int unsigned N    = 32,
    parameter int unsigned SIZE = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum_c,
    output logic         cout_c
);

    localparam int unsigned BLOCKS = N / SIZE;

    logic [BLOCKS:0] blk_carry;

    assign blk_carry[0] = cin;

    // Per-block dual sums, selected by the incoming block carry
    for (genvar g = 0; g < int'(BLOCKS); g++) begin : g_blk
        logic [SIZE:0] res0;
        logic [SIZE:0] res1;

        assign res0 = {1'b0, a[g*SIZE +: SIZE]} + {1'b0, b[g*SIZE +: SIZE]};
        assign res1 = {1'b0, a[g*SIZE +: SIZE]} + {1'b0, b[g*SIZE +: SIZE]} + (SIZE+1)'(1);

        assign sum_c[g*SIZE +: SIZE] = blk_carry[g] ? res1[SIZE-1:0] : res0[SIZE-1:0];
        assign blk_carry[g+1]        = blk_carry[g] ? res1[SIZE]     : res0[SIZE];
    end

    assign cout_c = blk_carry[BLOCKS];

endmodule

// File: rtl/wide_adder_sequencer.sv
// WIDTH-bit add/subtract processed one N-bit slice per cycle, LSB slice first,
// with the inter-slice carry held in a register.
module wide_adder_sequencer
    import wide_adder_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned N     = 32,
    parameter int unsigned SIZE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int unsigned STEPS = WIDTH / N;
    localparam int unsigned CW    = cnt_width(STEPS);
    localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

    // Parameter legality
    if ((WIDTH % N) != 0) begin : g_bad_width
        $error("wide_adder_sequencer: WIDTH must be a multiple of N");
    end
    if ((N % SIZE) != 0) begin : g_bad_size
        $error("wide_adder_sequencer: N must be a multiple of SIZE");
    end

    seq_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic             out_cout_q, out_cout_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [N-1:0]     slice_a;
    logic [N-1:0]     slice_b;
    logic [N-1:0]     slice_sum;
    logic             slice_cout;

    // Operand slice select for the shared adder
    always_comb begin
        slice_a = a_q[cnt_q*N +: N];
        slice_b = b_q[cnt_q*N +: N];
    end

    carry_select_adder #(
        .N    (N),
        .SIZE (SIZE)
    ) u_csa (
        .a      (slice_a),
        .b      (slice_b),
        .cin    (carry_q),
        .sum_c  (slice_sum),
        .cout_c (slice_cout)
    );

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        out_sum_d   = out_sum_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_sub ? ~in_b : in_b;
                    carry_d = in_sub | in_cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                out_sum_d[cnt_q*N +: N] = slice_sum;
                carry_d                 = slice_cout;
                cnt_d                   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    out_cout_d  = slice_cout;
                    out_ovf_d   = signed_ovf(slice_a[N-1], slice_b[N-1], slice_sum[N-1]);
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_wide_adder_sequencer.sv
// Directed and randomized checks of wide_adder_sequencer against an arithmetic reference.
module tb_wide_adder_sequencer;

    localparam int unsigned WIDTH = 128;
    localparam int unsigned N     = 32;
    localparam int unsigned SIZE  = 4;
    localparam int unsigned STEPS = WIDTH / N;
    localparam int unsigned NRAND = 2000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_sub = 1'b0;
    logic             in_cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } result_t;

    wide_adder_sequencer #(.WIDTH(WIDTH), .N(N), .SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: unsigned result/carry from wide arithmetic, overflow from exact signed value
    function automatic result_t ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic sub, input logic cin);
        result_t          r;
        logic [WIDTH:0]   u;
        logic signed [WIDTH+1:0] s;
        logic signed [WIDTH+1:0] wrapped;
        if (sub) begin
            u      = {1'b0, a} - {1'b0, b};
            r.cout = (a >= b);
            s      = $signed(a) - $signed(b);
        end else begin
            u      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            r.cout = u[WIDTH];
            s      = $signed(a) + $signed(b) + $signed({1'b0, cin});
        end
        r.sum   = u[WIDTH-1:0];
        wrapped = $signed(r.sum);
        r.ovf   = (s != wrapped);
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rand_operand();
        logic [WIDTH-1:0] v;
        for (int w = 0; w < int'(STEPS); w++) begin
            case ($urandom_range(0, 3))
                0:       v[w*N +: N] = '0;
                1:       v[w*N +: N] = '1;
                default: v[w*N +: N] = N'($urandom);
            endcase
        end
        return v;
    endfunction

    // Present one request and hold it until the accepting edge
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sub, input logic cin);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            err_cnt++;
            $display("FAIL issue_timeout: in_ready=%0b required 1", in_ready);
        end
        in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid is seen
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vec_cnt++;
        if ({out_valid, out_cout, out_ovf, busy, in_ready} !== 5'b00001 || out_sum !== '0) begin
            err_cnt++;
            $display("FAIL reset_state: valid/cout/ovf/busy/ready=%b sum=%h required 00001 sum=0",
                     {out_valid, out_cout, out_ovf, busy, in_ready}, out_sum);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_wrap();
        int lat;
        issue('1, WIDTH'(1), 1'b0, 1'b0);
        vec_cnt++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL add_wrap_busy: busy=%b in_ready=%b required 1 0", busy, in_ready);
        end
        wait_valid(lat);
        vec_cnt++;
        if (lat != int'(STEPS)) begin
            err_cnt++;
            $display("FAIL add_wrap_latency: got %0d cycles required %0d", lat, STEPS);
        end
        vec_cnt++;
        if (out_sum !== '0 || out_cout !== 1'b1 || out_ovf !== 1'b0) begin
            err_cnt++;
            $display("FAIL add_wrap_result: sum=%h cout=%b ovf=%b required 0 1 0", out_sum, out_cout, out_ovf);
        end
        consume();
        vec_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL add_wrap_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_sub();
        int lat;
        logic [WIDTH-1:0] exp_sum;
        exp_sum = '1;
        exp_sum[0] = 1'b0;
        issue(WIDTH'(5), WIDTH'(7), 1'b1, 1'b1);
        wait_valid(lat);
        vec_cnt++;
        if (out_sum !== exp_sum || out_cout !== 1'b0 || out_ovf !== 1'b0 || lat != int'(STEPS)) begin
            err_cnt++;
            $display("FAIL sub_5_7: sum=%h cout=%b ovf=%b lat=%0d required %h 0 0 %0d",
                     out_sum, out_cout, out_ovf, lat, exp_sum, STEPS);
        end
        consume();
    endtask

    task automatic test_ovf();
        int lat;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] exp_sum;
        a = '1;
        a[WIDTH-1] = 1'b0;
        exp_sum = '0;
        exp_sum[WIDTH-1] = 1'b1;
        issue(a, WIDTH'(1), 1'b0, 1'b0);
        wait_valid(lat);
        vec_cnt++;
        if (out_sum !== exp_sum || out_cout !== 1'b0 || out_ovf !== 1'b1) begin
            err_cnt++;
            $display("FAIL add_ovf: sum=%h cout=%b ovf=%b required %h 0 1", out_sum, out_cout, out_ovf, exp_sum);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        result_t exp;
        exp = ref_op(WIDTH'(128'h1234_5678_9abc_def0_0fed_cba9_8765_4321),
                     WIDTH'(128'hffff_0000_ffff_0000_ffff_0000_ffff_0000), 1'b0, 1'b1);
        issue(WIDTH'(128'h1234_5678_9abc_def0_0fed_cba9_8765_4321),
              WIDTH'(128'hffff_0000_ffff_0000_ffff_0000_ffff_0000), 1'b0, 1'b1);
        wait_valid(lat);
        in_a = '1; in_b = '1; in_sub = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
                out_sum !== exp.sum || out_cout !== exp.cout || out_ovf !== exp.ovf)
                bad++;
        end
        vec_cnt++;
        if (bad != 0) begin
            err_cnt++;
            $display("FAIL hold_stable: %0d unstable cycles required 0 (sum=%h exp %h)", bad, out_sum, exp.sum);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        vec_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL hold_release: in_ready=%b out_valid=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
        end
        repeat (STEPS + 2) @(posedge clk);
        #1;
        vec_cnt++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL hold_no_accept: busy=%b out_valid=%b required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int bad = 0;
        issue(WIDTH'(100), WIDTH'(200), 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vec_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_abort: out_valid=%b in_ready=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < int'(STEPS) + 3; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        vec_cnt++;
        if (bad != 0) begin
            err_cnt++;
            $display("FAIL reset_no_pulse: out_valid high %0d cycles required 0", bad);
        end
        issue(WIDTH'(3), WIDTH'(4), 1'b0, 1'b0);
        wait_valid(lat);
        vec_cnt++;
        if (out_sum !== WIDTH'(7) || out_cout !== 1'b0 || out_ovf !== 1'b0 || lat != int'(STEPS)) begin
            err_cnt++;
            $display("FAIL reset_next_op: sum=%h cout=%b ovf=%b lat=%0d required 7 0 0 %0d",
                     out_sum, out_cout, out_ovf, lat, STEPS);
        end
        consume();
    endtask

    task automatic test_random();
        result_t exp_q[$];
        result_t e;
        int accepted = 0;
        int retired  = 0;
        int cycles   = 0;
        logic [WIDTH-1:0] a, b;
        logic sub, cin, acc, hs;
        while ((accepted < int'(NRAND) || exp_q.size() != 0) && cycles < 80000) begin
            @(negedge clk);
            cycles++;
            a = rand_operand();
            b = rand_operand();
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            in_a = a; in_b = b; in_sub = sub; in_cin = cin;
            in_valid  = (accepted < int'(NRAND)) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (hs) begin
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL rand_spurious: result sum=%h with no request outstanding", out_sum);
                end else begin
                    e = exp_q.pop_front();
                    retired++;
                    if (out_sum !== e.sum || out_cout !== e.cout || out_ovf !== e.ovf) begin
                        err_cnt++;
                        $display("FAIL rand_result %0d: sum=%h cout=%b ovf=%b required %h %b %b",
                                 retired, out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
                    end
                end
            end
            if (acc) begin
                exp_q.push_back(ref_op(a, b, sub, cin));
                accepted++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        vec_cnt++;
        if (retired != int'(NRAND) || accepted != int'(NRAND)) begin
            err_cnt++;
            $display("FAIL rand_count: retired=%0d accepted=%0d required %0d", retired, accepted, NRAND);
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sub();
        test_ovf();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
